// File: rtl/mux2x1_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mux2x1_arbiter_pkg : state encoding and sizing helpers for the arbiter
// Revision: 1.0
// ============================================================================
package mux2x1_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT0  = 2'd1;
  localparam logic [1:0] ST_GRANT1  = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT0  = ST_GRANT0,
    GRANT1  = ST_GRANT1,
    ILLEGAL = ST_ILLEGAL
  } state_t;

  // Burst counter must represent 0..MAX_BURST.
  function automatic int count_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux2x1_arbiter_if.sv
`default_nettype none
// ============================================================================
// mux2x1_arbiter_if : requester/sink handshake bundle for mux2x1_arbiter
// Revision: 1.0
// ============================================================================
interface mux2x1_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             req0;
  logic [WIDTH-1:0] d0;
  logic             req1;
  logic [WIDTH-1:0] d1;
  logic             gnt0;
  logic             gnt1;
  logic             ack0;
  logic             ack1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  req0, d0, req1, d1, out_ready,
    output gnt0, gnt1, ack0, ack1, out_valid, out_data
  );

  modport master (
    output req0, d0, req1, d1, out_ready,
    input  gnt0, gnt1, ack0, ack1, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/Multiplexador2x1.sv
`default_nettype none
// ============================================================================
// Multiplexador2x1 : existing 1-bit 2:1 multiplexer cell (Y = S ? I1 : I0)
// Revision: 1.0
// ============================================================================
module Multiplexador2x1 (
  input  wire logic I0,
  input  wire logic I1,
  input  wire logic S,
  output logic      Y
);

  assign Y = S ? I1 : I0;

endmodule
`default_nettype wire

// File: rtl/mux2x1_arbiter_datapath.sv
`default_nettype none
// ============================================================================
// mux2x1_arbiter_datapath : WIDTH-bit 2:1 mux built from Multiplexador2x1 cells
// Revision: 1.0
// ============================================================================
module mux2x1_arbiter_datapath #(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] d0,
  input  wire logic [WIDTH-1:0] d1,
  input  wire logic             sel,
  output logic      [WIDTH-1:0] y
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      Multiplexador2x1 u_mux (
        .I0 (d0[i]),
        .I1 (d1[i]),
        .S  (sel),
        .Y  (y[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mux2x1_arbiter.sv
`default_nettype none
// ============================================================================
// mux2x1_arbiter : round-robin, burst-limited sharing of one registered channel
// Revision: 1.0
// ============================================================================
module mux2x1_arbiter
  import mux2x1_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  mux2x1_arbiter_if.slave   bus
);

  localparam int              CW         = count_width(MAX_BURST);
  localparam logic [CW-1:0]   BURST_LAST = CW'(MAX_BURST - 1);

  state_t           state;
  logic             last;
  logic [CW-1:0]    count;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] mux_y;

  logic gnt0;
  logic gnt1;
  logic accept;
  logic ack0;
  logic ack1;
  logic burst_done;
  logic release0;
  logic release1;

  assign gnt0   = (state == GRANT0);
  assign gnt1   = (state == GRANT1);
  assign accept = !out_valid || bus.out_ready;
  assign ack0   = gnt0 && bus.req0 && accept;
  assign ack1   = gnt1 && bus.req1 && accept;

  // This ack is the MAX_BURST-th word of the current grant.
  assign burst_done = (count == BURST_LAST);
  assign release0   = !bus.req0 || (ack0 && burst_done);
  assign release1   = !bus.req1 || (ack1 && burst_done);

  mux2x1_arbiter_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .d0  (bus.d0),
    .d1  (bus.d1),
    .sel (gnt1),
    .y   (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (ack0 || ack1) begin
        out_data  <= mux_y;
        out_valid <= 1'b1;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            state <= last ? GRANT0 : GRANT1;
          end else if (bus.req0) begin
            state <= GRANT0;
          end else if (bus.req1) begin
            state <= GRANT1;
          end
        end
        GRANT0: begin
          if (release0) begin
            count <= '0;
            last  <= 1'b0;
            if (bus.req1) begin
              state <= GRANT1;
            end else if (bus.req0) begin
              state <= GRANT0;
            end else begin
              state <= IDLE;
            end
          end else if (ack0) begin
            count <= count + 1'b1;
          end
        end
        GRANT1: begin
          if (release1) begin
            count <= '0;
            last  <= 1'b1;
            if (bus.req0) begin
              state <= GRANT0;
            end else if (bus.req1) begin
              state <= GRANT1;
            end else begin
              state <= IDLE;
            end
          end else if (ack1) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule
`default_nettype wire

// File: tb/tb_mux2x1_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux2x1_arbiter : directed self-checking bench for mux2x1_arbiter
// Revision: 1.0
// ============================================================================
module tb_mux2x1_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  mux2x1_arbiter_if #(.WIDTH(8)) bus ();

  mux2x1_arbiter #(
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req0      = 1'b0;
    bus.req1      = 1'b0;
    bus.d0        = 8'h00;
    bus.d1        = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    bus.req0 = 1'b1;
    #1;
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_ack0", bus.ack0, 0);

    // Contention from reset: requester 0 wins the first tie
    tick();
    rst_n    = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.d0   = 8'hA0;
    bus.d1   = 8'hB0;
    #1;
    chk("c0_idle_gnt0", bus.gnt0, 0);
    chk("c0_idle_ack0", bus.ack0, 0);
    tick();
    #1;
    chk("c1_gnt0", bus.gnt0, 1);
    chk("c1_gnt1", bus.gnt1, 0);
    chk("c1_ack0", bus.ack0, 1);
    chk("c1_ack1", bus.ack1, 0);
    chk("c1_valid", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.d0 = 8'hA1 + 8'(i);
      #1;
      chk("cA_data", bus.out_data, 8'hA0 + 8'(i));
    end
    chk("c5_gnt1", bus.gnt1, 1);
    chk("c5_gnt0", bus.gnt0, 0);
    chk("c5_ack1", bus.ack1, 1);
    tick();
    bus.d1 = 8'hB1;
    #1;
    chk("c6_data", bus.out_data, 8'hB0);
    chk("c6_ack1", bus.ack1, 1);

    // Backpressure during GRANT1
    tick();
    bus.d1        = 8'hB2;
    bus.out_ready = 1'b0;
    #1;
    chk("bp0_data", bus.out_data, 8'hB1);
    chk("bp0_ack1", bus.ack1, 0);
    chk("bp0_valid", bus.out_valid, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("bp_data", bus.out_data, 8'hB1);
      chk("bp_ack1", bus.ack1, 0);
      chk("bp_valid", bus.out_valid, 1);
    end
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_end_data", bus.out_data, 8'hB1);
    chk("bp_end_ack1", bus.ack1, 1);
    chk("bp_end_gnt1", bus.gnt1, 1);
    tick();
    bus.d1 = 8'hB3;
    #1;
    chk("c11_data", bus.out_data, 8'hB2);
    tick();
    #1;
    chk("c12_data", bus.out_data, 8'hB3);
    chk("c12_gnt0", bus.gnt0, 1);
    chk("c12_gnt1", bus.gnt1, 0);
    chk("c12_ack0", bus.ack0, 1);
    tick();
    #1;
    chk("c13_data", bus.out_data, 8'hA4);
    chk("c13_valid", bus.out_valid, 1);

    // Asynchronous reset mid-burst
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 8'h00);
    chk("arst_gnt0", bus.gnt0, 0);
    chk("arst_ack0", bus.ack0, 0);

    // Early drop of requester 0 after two acks
    tick();
    rst_n  = 1'b1;
    bus.d0 = 8'hC0;
    bus.d1 = 8'hD0;
    #1;
    chk("r0_gnt0", bus.gnt0, 0);
    tick();
    #1;
    chk("r1_gnt0", bus.gnt0, 1);
    chk("r1_gnt1", bus.gnt1, 0);
    chk("r1_ack0", bus.ack0, 1);
    tick();
    bus.d0 = 8'hC1;
    #1;
    chk("r2_data", bus.out_data, 8'hC0);
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("r3_data", bus.out_data, 8'hC1);
    chk("r3_ack0", bus.ack0, 0);
    chk("r3_gnt0", bus.gnt0, 1);
    tick();
    #1;
    chk("r4_gnt1", bus.gnt1, 1);
    chk("r4_gnt0", bus.gnt0, 0);
    chk("r4_valid", bus.out_valid, 0);
    chk("r4_data", bus.out_data, 8'hC1);
    chk("r4_ack1", bus.ack1, 1);
    tick();
    bus.req1 = 1'b0;
    #1;
    chk("r5_data", bus.out_data, 8'hD0);
    chk("r5_valid", bus.out_valid, 1);
    chk("r5_ack1", bus.ack1, 0);
    tick();
    #1;
    chk("r6_gnt0", bus.gnt0, 0);
    chk("r6_gnt1", bus.gnt1, 0);
    chk("r6_valid", bus.out_valid, 0);

    // Single requester: burst expiry with no competitor keeps the grant
    bus.req0 = 1'b1;
    bus.d0   = 8'h11;
    #1;
    chk("s0_gnt0", bus.gnt0, 0);
    chk("s0_ack0", bus.ack0, 0);
    tick();
    #1;
    chk("s1_gnt0", bus.gnt0, 1);
    chk("s1_ack0", bus.ack0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) bus.d0 = 8'h12 + 8'(i);
      else       bus.req0 = 1'b0;
      #1;
      chk("s_data", bus.out_data, 8'h11 + 8'(i));
      chk("s_gnt0", bus.gnt0, 1);
      chk("s_valid", bus.out_valid, 1);
    end
    tick();
    #1;
    chk("s8_gnt0", bus.gnt0, 0);
    chk("s8_gnt1", bus.gnt1, 0);
    chk("s8_valid", bus.out_valid, 0);
    chk("s8_data", bus.out_data, 8'h16);

    // Last served was requester 0, so a tie now goes to requester 1
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.d0   = 8'hE0;
    bus.d1   = 8'hF0;
    tick();
    #1;
    chk("t_gnt1", bus.gnt1, 1);
    chk("t_gnt0", bus.gnt0, 0);
    chk("t_ack1", bus.ack1, 1);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1;
    chk("t_data", bus.out_data, 8'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
